// File: rtl/rgb2ycbcr_matrix_pkg.sv
// Shared BT.601 full-range coefficients (FRAC=10), pipeline widths and the output saturate helper.
package rgb2ycbcr_matrix_pkg;

  localparam int COEF_FRAC = 10;
  localparam int COEF_W    = 11;
  localparam int PROD_W    = 19;
  localparam int SUM_W     = 20;
  localparam int LATENCY   = 3;

  localparam logic signed [COEF_W-1:0] C_YR  = 11'sd306;
  localparam logic signed [COEF_W-1:0] C_YG  = 11'sd601;
  localparam logic signed [COEF_W-1:0] C_YB  = 11'sd117;
  localparam logic signed [COEF_W-1:0] C_CBR = -11'sd173;
  localparam logic signed [COEF_W-1:0] C_CBG = -11'sd339;
  localparam logic signed [COEF_W-1:0] C_CBB = 11'sd512;
  localparam logic signed [COEF_W-1:0] C_CRR = 11'sd512;
  localparam logic signed [COEF_W-1:0] C_CRG = -11'sd429;
  localparam logic signed [COEF_W-1:0] C_CRB = -11'sd83;

  // Row-major: Y, Cb, Cr rows, each ordered R, G, B.
  localparam logic signed [COEF_W-1:0] COEF [9] = '{
    C_YR,  C_YG,  C_YB,
    C_CBR, C_CBG, C_CBB,
    C_CRR, C_CRG, C_CRB
  };

  // Saturate an already-shifted sum to [0, 255].
  function automatic logic [7:0] clamp_u8(input logic signed [SUM_W-1:0] v);
    if (v[SUM_W-1])          return 8'd0;
    else if (|v[SUM_W-2:8])  return 8'd255;
    else                     return v[7:0];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_matrix_delayline.sv
// Generic ce-qualified shift register; DELAY stages, each WIDTH bits, cleared by async reset.
module delayLine #(
  parameter int DELAY = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DELAY];
  logic [WIDTH-1:0] stage_d [DELAY];

  always_comb begin
    for (int i = 0; i < DELAY; i++) stage_d[i] = stage_q[i];
    if (ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DELAY; i++) stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DELAY; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[DELAY-1];

endmodule

// File: rtl/rgb2ycbcr_matrix.sv
// Pipelined BT.601 RGB->YCbCr matrix: multiply, sum, shift+clamp; 3 ce-cycles latency.
// Sync bits ride a matching delayLine; ce=0 freezes data and sync together.
module rgb2ycbcr_matrix
  import rgb2ycbcr_matrix_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = COEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] cb_out,
  output logic [WIDTH-1:0] cr_out,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out
);

  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) <<< (FRAC - 1);
  localparam logic signed [SUM_W-1:0] OFF = SUM_W'(128) <<< FRAC;

  function automatic logic signed [PROD_W-1:0] mul(input logic [WIDTH-1:0] x,
                                                   input logic signed [COEF_W-1:0] c);
    return $signed({{(PROD_W-WIDTH){1'b0}}, x}) * PROD_W'(c);
  endfunction

  logic [WIDTH-1:0]        px [3];
  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [SUM_W-1:0]  sum_d  [3];
  logic signed [SUM_W-1:0]  sum_q  [3];
  logic signed [SUM_W-1:0]  sh     [3];
  logic [WIDTH-1:0]         y_d, cb_d, cr_d;
  logic [WIDTH-1:0]         y_q, cb_q, cr_q;

  always_comb begin
    px[0] = r_in;
    px[1] = g_in;
    px[2] = b_in;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = ce ? mul(px[i % 3], COEF[i]) : prod_q[i];
    end
  end

  // Chroma rows sum to zero, so the 128 offset is folded in before the shift.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sum_d[k] = sum_q[k];
      if (ce) begin
        sum_d[k] = SUM_W'(prod_q[3*k]) + SUM_W'(prod_q[3*k+1]) + SUM_W'(prod_q[3*k+2]) + RND;
        if (k != 0) sum_d[k] = sum_d[k] + OFF;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) sh[k] = sum_q[k] >>> FRAC;
    y_d  = y_q;
    cb_d = cb_q;
    cr_d = cr_q;
    if (ce) begin
      y_d  = WIDTH'(clamp_u8(sh[0]));
      cb_d = WIDTH'(clamp_u8(sh[1]));
      cr_d = WIDTH'(clamp_u8(sh[2]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int k = 0; k < 3; k++) sum_q[k]  <= '0;
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      for (int k = 0; k < 3; k++) sum_q[k]  <= sum_d[k];
      y_q  <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end

  assign y_out  = y_q;
  assign cb_out = cb_q;
  assign cr_out = cr_q;

  delayLine #(
    .DELAY (LATENCY),
    .WIDTH (3)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  ({de_in, hs_in, vs_in}),
    .dout ({de_out, hs_out, vs_out})
  );

endmodule

// File: tb/tb_rgb2ycbcr_matrix.sv
// Scoreboard bench for rgb2ycbcr_matrix: directed pixels with hand-computed Y/Cb/Cr expectations.
module tb_rgb2ycbcr_matrix;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] r_in, g_in, b_in;
  logic       de_in, hs_in, vs_in;
  logic [7:0] y_out, cb_out, cr_out;
  logic       de_out, hs_out, vs_out;

  rgb2ycbcr_matrix #(.WIDTH(8), .FRAC(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .r_in   (r_in),
    .g_in   (g_in),
    .b_in   (b_in),
    .de_in  (de_in),
    .hs_in  (hs_in),
    .vs_in  (vs_in),
    .y_out  (y_out),
    .cb_out (cb_out),
    .cr_out (cr_out),
    .de_out (de_out),
    .hs_out (hs_out),
    .vs_out (vs_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y, cb, cr;
    logic       hs, vs;
    int         due;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   ce_cnt = 0;

  logic        mon_ce, mon_rst;
  logic [26:0] prev_out;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; push=1 records the expected result of a consumed pixel.
  task automatic drive(input logic c, input logic [7:0] r, g, b,
                       input logic de, hs, vs, input bit push,
                       input logic [7:0] ey, ecb, ecr);
    @(negedge clk);
    ce = c; r_in = r; g_in = g; b_in = b;
    de_in = de; hs_in = hs; vs_in = vs;
    if (push) begin
      exp_t e;
      e.y = ey; e.cb = ecb; e.cr = ecr; e.hs = hs; e.vs = vs;
      e.due = ce_cnt + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // Monitor: a new output exists only after a ce-qualified edge; ce=0 edges must hold.
  always begin
    @(posedge clk);
    mon_ce  = ce;
    mon_rst = rst;
    if (mon_ce && !mon_rst) ce_cnt++;
    #1;
    if (!mon_rst && mon_ce && de_out) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pixel: de_out=1 with y=%0d cb=%0d cr=%0d, expected no pixel", y_out, cb_out, cr_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y",       y_out,  e.y);
        chk("cb",      cb_out, e.cb);
        chk("cr",      cr_out, e.cr);
        chk("hs_out",  hs_out, e.hs);
        chk("vs_out",  vs_out, e.vs);
        chk("latency", ce_cnt, e.due);
      end
    end else if (!mon_rst && !mon_ce) begin
      chk("hold_on_ce0", {y_out, cb_out, cr_out, de_out, hs_out, vs_out}, prev_out);
    end
    prev_out = {y_out, cb_out, cr_out, de_out, hs_out, vs_out};
  end

  initial begin
    rst = 1'b1; ce = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y",  y_out,  0);
    chk("rst_cb", cb_out, 0);
    chk("rst_cr", cr_out, 0);
    chk("rst_de", de_out, 0);
    chk("rst_hs", hs_out, 0);
    chk("rst_vs", vs_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Primaries and extremes, continuous ce.
    drive(1, 8'd255, 8'd255, 8'd255, 1, 1, 0, 1, 8'd255, 8'd128, 8'd128);
    drive(1, 8'd0,   8'd0,   8'd0,   1, 0, 1, 1, 8'd0,   8'd128, 8'd128);
    drive(1, 8'd255, 8'd0,   8'd0,   1, 1, 1, 1, 8'd76,  8'd85,  8'd255);
    drive(1, 8'd0,   8'd0,   8'd255, 1, 0, 0, 1, 8'd29,  8'd255, 8'd107);
    drive(1, 8'd0,   8'd255, 8'd0,   1, 1, 0, 1, 8'd150, 8'd44,  8'd21);
    idle(5);

    // ce pattern 1,0,0,1,1,0,1 while streaming red, green, blue.
    drive(1, 8'd255, 8'd0,   8'd0,   1, 0, 1, 1, 8'd76,  8'd85,  8'd255);
    drive(0, 8'd0,   8'd255, 8'd0,   1, 1, 0, 0, 8'd0,   8'd0,   8'd0);
    drive(0, 8'd0,   8'd255, 8'd0,   1, 1, 0, 0, 8'd0,   8'd0,   8'd0);
    drive(1, 8'd0,   8'd255, 8'd0,   1, 1, 0, 1, 8'd150, 8'd44,  8'd21);
    drive(1, 8'd0,   8'd0,   8'd255, 1, 1, 1, 1, 8'd29,  8'd255, 8'd107);
    drive(0, 8'd0,   8'd0,   8'd0,   0, 0, 0, 0, 8'd0,   8'd0,   8'd0);
    drive(1, 8'd0,   8'd0,   8'd0,   0, 0, 0, 0, 8'd0,   8'd0,   8'd0);
    idle(5);

    // Mid-flight reset: red reaches the output, two unrecorded pixels are killed.
    drive(1, 8'd255, 8'd0,   8'd0,   1, 1, 1, 1, 8'd76,  8'd85,  8'd255);
    drive(1, 8'd10,  8'd20,  8'd30,  1, 1, 0, 0, 8'd0,   8'd0,   8'd0);
    drive(1, 8'd200, 8'd100, 8'd50,  1, 0, 1, 0, 8'd0,   8'd0,   8'd0);
    @(negedge clk);
    rst = 1'b1;
    r_in = '0; g_in = '0; b_in = '0;
    de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    #1;
    chk("arst_y",  y_out,  0);
    chk("arst_cb", cb_out, 0);
    chk("arst_cr", cr_out, 0);
    chk("arst_sync", {de_out, hs_out, vs_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 8'd0, 8'd255, 8'd0, 1, 1, 0, 1, 8'd150, 8'd44, 8'd21);
    idle(6);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb2ycbcr_matrix.md
Name: rgb2ycbcr_matrix

Overview:
Pipelined BT.601 RGB to YCbCr colour-space matrix for the lab6 video path.
- Consumes one RGB pixel per enabled clock and produces full-range 8-bit Y/Cb/Cr.
- Routes the pixel's sync/enable bits through the existing delayLine so that data and sync arrive aligned at the output.
- Sits between the pixel source (camera/timing generator) and the downstream YCbCr consumer.

Parameters:
- WIDTH, 8, component width in bits for inputs and outputs. Only 8 is verified.
- FRAC, 10, coefficient fraction bits. Coefficients are given below for FRAC=10.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ce  in  1  clock enable; when 0, the whole pipeline holds
- r_in  in  WIDTH  red, unsigned
- g_in  in  WIDTH  green, unsigned
- b_in  in  WIDTH  blue, unsigned
- de_in  in  1  pixel data enable
- hs_in  in  1  hsync
- vs_in  in  1  vsync
- y_out  out  WIDTH  luma, unsigned
- cb_out  out  WIDTH  blue-difference chroma, offset 128
- cr_out  out  WIDTH  red-difference chroma, offset 128
- de_out  out  1  de_in delayed by LATENCY
- hs_out  out  1  hs_in delayed by LATENCY
- vs_out  out  1  vs_in delayed by LATENCY

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset clears every pipeline register and every delay stage. All outputs are 0 while rst=1 and until valid data has propagated.
- LATENCY = 3 ce-qualified cycles. When ce=0, nothing advances and the outputs hold their values.
- Coefficients, signed, FRAC=10:
  - Y = 306, 601, 117
  - Cb = -173, -339, 512
  - Cr = 512, -429, -83
- Coefficient row sums are 1024, 0 and 0. OFF = 128<<FRAC. RND = 1<<(FRAC-1).
- Stage 1: nine registered products, each unsigned WIDTH x signed 11-bit, signed 19 bits. Inputs are zero-extended before multiplying.
- Stage 2: three registered sums, signed 20 bits.
  - Y sum = products + RND
  - Cb sum = products + OFF + RND
  - Cr sum = products + OFF + RND
- Stage 3: arithmetic shift right by FRAC, then clamp to [0, 255] and register.
  - Negative values give 0.
  - Values ≥256 give 255.
  - Clamping is required because saturated red and blue reach 256.
- Sync path: {de, hs, vs} passes through one delayLine instance with DELAY=3, WIDTH=3, sharing ce/rst/clk. It is bit-aligned with the data path.
- Data is computed regardless of de_in. The consumer qualifies data with de_out.
- Reset mid-frame: outputs return to 0 immediately (asynchronous). After rst falls, the first valid pixel appears 3 ce-cycles after it is presented. No stale data may emerge.
- ce toggling on any cycle pattern must not drop, duplicate or misalign a pixel between the data path and the sync path.

Decomposition:
- Shared include rgb2ycbcr_coefs.vh holds:
  - the nine coefficient localparams
  - FRAC, OFF, RND
  - LATENCY=3
  - product width (19) and sum width (20)
- Sub-module: the existing delayLine for the sync bits.
- The matrix arithmetic stays inline. One optional helper, clamp_u8 (combinational saturate), is allowed.

Test Plan:
1. White (255,255,255), de=1, ce=1 → after 3 cycles Y=255, Cb=128, Cr=128, de_out=1.
2. Black (0,0,0) → Y=0, Cb=128, Cr=128.
3. Red (255,0,0) → Y=76, Cb=85, Cr=255 (raw 256 clamped).
4. Blue (0,0,255) → Y=29, Cb=255 (clamped), Cr=107. Green (0,255,0) → Y=150, Cb=44, Cr=21.
5. Stream the pixels red, green, blue with ce pattern 1,0,0,1,1,0,1 → the output sequence and the de/hs/vs alignment equal the ce=1 run; the outputs hold on ce=0 cycles.
6. Assert rst for 1 cycle while 2 pixels are in flight → all outputs 0 asynchronously. The next pixel appears exactly 3 ce-cycles after release, and the in-flight pixels are never emitted.
